// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback and
// Moore-decodes datapath selects and write strobes. Define MULTICYCLE_TRAP_EN to trap on unknown opcodes.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [2:0] AddressingControl,
    output logic [1:0] ResultSrc,
    output logic [3:0] state
);

    // state     | meaning
    // FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
    // DECODE    | ALUOut <= OldPC+imm, dispatch on opcode
    // MEMADR    | ALUOut <= rs1+imm
    // MEMREAD   | load access at ALUOut
    // MEMWB     | rd <= memory data
    // MEMWRITE  | store access at ALUOut
    // EXECR     | ALUOut <= rs1 op rs2
    // EXECI     | ALUOut <= rs1 op imm
    // ALUWB     | rd <= ALUOut
    // BRANCH    | PC <= ALUOut when taken
    // JAL       | PC <= ALUOut, ALUOut <= OldPC+4
    // JALR      | PC <= rs1+imm
    // JALR_LINK | rd <= OldPC+4
    // EXECU     | ALUOut <= imm (LUI) or OldPC+imm (AUIPC)
    // TRAP      | illegal opcode, parked until reset
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB     = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECR  = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB     = 4'd8,  S_BRANCH   = 4'd9,  S_JAL    = 4'd10, S_JALR    = 4'd11,
        S_JALR_LINK = 4'd12, S_EXECU    = 4'd13, S_TRAP   = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R     = 7'b0110011,
                           OP_I    = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;

    // ALUControl: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 15 pass B
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_PASSB = 4'd15;

    state_t state_q, state_d;
    logic [2:0] imm_sel;
    logic       alt_op;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic r_type);
        case (f3)
            3'b000:  return (r_type && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign alt_op = (funct7 == 7'b0100000);

    // ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U
    always_comb begin
        imm_sel = 3'b000;
        case (opcode)
            OP_STORE:          imm_sel = 3'b001;
            OP_BR:             imm_sel = 3'b010;
            OP_JAL:            imm_sel = 3'b011;
            OP_LUI, OP_AUIPC:  imm_sel = 3'b100;
            default:           imm_sel = 3'b000;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        mem_req           = 1'b0;
        AdrSrc            = 1'b0;
        IRWrite           = 1'b0;
        PCWrite           = 1'b0;
        RegWrite          = 1'b0;
        MemWrite          = 1'b0;
        ALUSrcA           = 2'b00;
        ALUSrcB           = 2'b00;
        ALUControl        = ALU_ADD;
        ImmSrc            = 3'b000;
        AddressingControl = 3'b000;
        ResultSrc         = 2'b00;
        state             = state_q;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_sel;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_EXECU;
`ifdef MULTICYCLE_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = imm_sel;
                state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req           = 1'b1;
                AdrSrc            = 1'b1;
                AddressingControl = funct3;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req           = 1'b1;
                AdrSrc            = 1'b1;
                MemWrite          = 1'b1;
                AddressingControl = funct3;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op(funct3, alt_op, 1'b1);
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = imm_sel;
                ALUControl = alu_op(funct3, alt_op, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = branch_taken;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ImmSrc    = imm_sel;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECU: begin
                ImmSrc  = 3'b100;
                ALUSrcB = 2'b01;
                if (opcode == OP_LUI) ALUControl = ALU_PASSB;
                else                  ALUSrcA    = 2'b01;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset wins over every state: nothing may strobe while rst is high.
        if (rst) begin
            mem_req           = 1'b0;
            AdrSrc            = 1'b0;
            IRWrite           = 1'b0;
            PCWrite           = 1'b0;
            RegWrite          = 1'b0;
            MemWrite          = 1'b0;
            ALUSrcA           = 2'b00;
            ALUSrcB           = 2'b00;
            ALUControl        = 4'd0;
            ImmSrc            = 3'b000;
            AddressingControl = 3'b000;
            ResultSrc         = 2'b00;
            state             = 4'd0;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 opcode/funct3/funct7  in  7/3/7  fields of the latched instruction register.
REQ-004 mem_ready  in  1  memory handshake completion for the current mem_req.
REQ-005 branch_taken  in  1  branch-condition result from the comparator (eq/ne/lt/ge/ltu/geu per funct3).
REQ-006 mem_req  out  1  memory access request, held until mem_ready.
REQ-007 AdrSrc  out  1  memory address select (0 = PC, 1 = ALUOut).
REQ-008 IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write strobes.
REQ-009 ALUSrcA  out  2  (00 = PC, 01 = OldPC, 10 = rs1 reg); ALUSrcB  out  2  (00 = rs2 reg, 01 = imm, 10 = const 4).
REQ-010 ALUControl  out  4, ImmSrc  out  3, AddressingControl  out  3  with the existing decoder encodings.
REQ-011 ResultSrc  out  2  (00 = ALUOut, 01 = memory data, 10 = ALUResult).
REQ-012 state  out  4  current state encoding, debug only.

Function
REQ-013 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALR_LINK 12, EXECU 13, TRAP 14.
REQ-014 Outputs SHALL be Moore-decoded from state, except PCWrite in BRANCH (= branch_taken) and IRWrite/PCWrite in FETCH (= mem_ready).
REQ-015 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; stay in FETCH until mem_ready, then IRWrite=PCWrite=1 and go to DECODE.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut); ImmSrc from opcode; next state by opcode: load/store->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, JAL->JAL, JALR->JALR, LUI/AUIPC->EXECU.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, add; next MEMREAD (load) or MEMWRITE (store).
REQ-018 MEMREAD/MEMWRITE: mem_req=1, AdrSrc=1, AddressingControl=funct3, MemWrite=1 only in MEMWRITE; hold until mem_ready; then MEMWB or FETCH.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-020 EXECR/EXECI: ALUSrcA=10, ALUSrcB 00/01, ALUControl per funct3/funct7 (srai on funct7=0100000); next ALUWB.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, PCWrite=branch_taken; next FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB (rd = OldPC+4).
REQ-024 JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1; next JALR_LINK.
REQ-025 JALR_LINK: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1; next FETCH.
REQ-026 EXECU: ImmSrc=100, ALUSrcB=01; LUI ALUControl=1111, AUIPC ALUSrcA=01 with add; next ALUWB.
REQ-027 Latency excluding memory waits SHALL be: load 5, store/R/I/JAL/JALR/U 4, branch 3 cycles.
REQ-028 mem_ready SHALL be ignored outside FETCH/MEMREAD/MEMWRITE; mem_ready asserted on the same cycle as mem_req rises SHALL complete the access in that cycle.

Reset
REQ-029 While rst is high at a rising edge, state SHALL become FETCH; all outputs SHALL be 0 while rst is high, regardless of state or mem_ready.
REQ-030 rst asserted mid-instruction (including during a pending mem wait) SHALL abandon it with no further write strobes.

Configuration
REQ-031 Macro MULTICYCLE_TRAP_EN defined: unknown opcode in DECODE -> TRAP, all strobes 0, state held until rst; undefined: unknown opcode -> FETCH (treated as NOP, PC already advanced).

Verification
REQ-032 add x3,x1,x2 with mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB, ResultSrc=00.
REQ-033 lw, mem_ready low 3 cycles in MEMREAD -> mem_req held 4 cycles, AdrSrc=1, MEMWB RegWrite=1, ResultSrc=01.
REQ-034 beq with branch_taken=1 then 0 -> PCWrite=1 then 0 in BRANCH, 3-cycle instruction.
REQ-035 jalr -> JALR PCWrite=1 ResultSrc=10, JALR_LINK RegWrite=1 ALUSrcA=01 ALUSrcB=10.
REQ-036 rst pulsed during MEMWRITE wait -> next state FETCH, MemWrite=0 during and after reset.
REQ-037 opcode 0000000 -> TRAP (state=14) with MULTICYCLE_TRAP_EN; FETCH without it.
